// File: rtl/dp_ram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the dual-port-RAM FIFO controller.
// Depth, total capacity and count width all derive from the RAM address width.
package dp_ram_fifo_ctrl_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // The output buffer adds two words on top of the RAM.
    function automatic int fifo_capacity(input int addr_width);
        return fifo_depth(addr_width) + 2;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/dp_ram_fifo_ctrl_out_buf.sv
// Two-entry first-word-fall-through buffer that sits behind the RAM read port.
// The head entry drives data directly, so data is stable while valid is held.
module fifo_out_buf
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [1:0]            n;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: the two data entries are reset because the head is visible on m_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            n    <= 2'd0;
        end else if (clr) begin
            n <= 2'd0;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (n == 2'd0) head <= wr_data;
                    else           tail <= wr_data;
                    n <= n + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    n    <= n - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (n == 2'd1) begin
                        head <= wr_data;
                    end else begin
                        head <= tail;
                        tail <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (n != 2'd0);
    assign data  = head;
    assign cnt   = n;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM (A = write, B = read).
// Holds the pointers and read-issue logic; a 2-entry buffer hides the RAM read latency.
module dp_ram_fifo_ctrl
    import dp_ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_rden,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] ram_cnt;
    logic                ram_full;
    logic                ram_empty;
    logic                pend;
    logic                accept;
    logic                pop;
    logic [1:0]          buf_cnt;

    // Occupancy comes from the modular pointer difference, which stays correct across wrap.
    assign ram_cnt   = wptr - rptr;
    assign ram_full  = (ram_cnt == DEPTH);
    assign ram_empty = (ram_cnt == '0);

    assign s_ready = !ram_full;
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    assign ram_wren  = accept;
    assign ram_waddr = wptr[ADDR_WIDTH-1:0];
    assign ram_wdata = s_data;

    // Issue only if the buffer has room for this word after any in-flight read lands.
    assign ram_rden  = !ram_empty &&
                       (({1'b0, buf_cnt} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));
    assign ram_raddr = rptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            pend <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            pend <= 1'b0;
        end else begin
            if (accept)   wptr <= wptr + PTR_ONE;
            if (ram_rden) rptr <= rptr + PTR_ONE;
            pend <= ram_rden;
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (pend && !clr),
        .wr_data (ram_rdata),
        .pop     (pop),
        .valid   (m_valid),
        .data    (m_data),
        .cnt     (buf_cnt)
    );

    assign count = {1'b0, ram_cnt} + {{(ADDR_WIDTH+1){1'b0}}, pend} + {{ADDR_WIDTH{1'b0}}, buf_cnt};

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Self-checking bench: controller plus a behavioural dual-port RAM, checked every
// cycle against a queue model, with directed scenarios pinning literal values.
module tb_dp_ram_fifo_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int D   = 4;
    localparam int CAP = D + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          ram_wren;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_rden;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [D];

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    dp_ram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .ram_wren  (ram_wren),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_rden  (ram_rden),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Dual-port RAM: registered read, X when not read, write-through bypass on collision.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
        if (ram_rden) ram_rdata <= (ram_wren && ram_waddr == ram_raddr) ? ram_wdata : mem[ram_raddr];
        else          ram_rdata <= 'x;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the FIFO is just an ordered queue of accepted words.
    logic [DW-1:0] q[$];
    int            stall = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall = 0;
        end else begin
            check("count", 32'(count), 32'(q.size()));
            check("ram_conflict", 32'(ram_wren && ram_rden && ram_waddr == ram_raddr), 32'd0);
            if (q.size() == 0) check("m_valid_when_empty", 32'(m_valid), 32'd0);
            else if (m_valid)  check("m_data_head", 32'(m_data), 32'(q[0]));
            if (q.size() < D)   check("s_ready_room", 32'(s_ready), 32'd1);
            if (q.size() >= CAP) check("s_ready_full", 32'(s_ready), 32'd0);
            if (q.size() != 0 && !m_valid) stall++;
            else                           stall = 0;
            if (stall > 2) check("fwft_latency", 32'(stall), 32'd2);

            if (clr) begin
                q.delete();
                stall = 0;
            end else begin
                if (m_valid && m_ready) begin
                    if (q.size() == 0) check("pop_from_empty", 32'd1, 32'd0);
                    else               void'(q.pop_front());
                end
                if (s_valid && s_ready) q.push_back(s_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  v;
        int  j;
        int  n;
        int  c0;
        bit  acc;
        int  phase;

        // 1. Reset and idle.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_ram_rden", 32'(ram_rden), 32'd0);

        // 2. Single word latency: accepted at edge k, visible after edge k+2.
        tick();
        s_valid = 1'b1;
        s_data  = 8'h11;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("lat_k_valid", 32'(m_valid), 32'd0);
        check("lat_k_count", 32'(count), 32'd1);
        tick();
        @(negedge clk);
        check("lat_k1_valid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat_k2_valid", 32'(m_valid), 32'd1);
        check("lat_k2_data", 32'(m_data), 32'h11);
        check("lat_k2_count", 32'(count), 32'd1);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("lat_drained", 32'(count), 32'd0);

        // 3. Fill to capacity with the sink stalled, then drain in order.
        tick();
        v = 1;
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = 8'(v);
            @(negedge clk);
            acc = s_ready;
            tick();
            if (acc) v++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        check("full_accepted", 32'(v - 1), 32'd6);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_count", 32'(count), 32'd6);
        check("full_head", 32'(m_data), 32'h01);
        tick();
        m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(m_valid), 32'd1);
            check("drain_data", 32'(m_data), 32'(i));
            tick();
        end
        m_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", 32'(count), 32'd0);

        // 4. Continuous streaming across pointer wrap: one word per clock, constant count.
        tick();
        j  = 0;
        n  = 0;
        c0 = 0;
        for (int c = 0; c < 60 && j < 20; c++) begin
            s_valid = (n < 23);
            s_data  = 8'(8'h40 + n);
            m_ready = 1'b1;
            @(negedge clk);
            acc = s_valid && s_ready;
            if (m_valid) begin
                check("stream_data", 32'(m_data), 32'(8'h40 + j));
                if (j == 0) c0 = int'(count);
                else        check("stream_count", 32'(count), 32'(c0));
                j++;
            end else if (j > 0) begin
                check("stream_throughput", 32'(m_valid), 32'd1);
            end
            tick();
            if (acc) n++;
        end
        check("stream_words", 32'(j), 32'd20);
        s_valid = 1'b0;
        repeat (8) tick();
        m_ready = 1'b0;
        @(negedge clk);
        check("stream_drained", 32'(count), 32'd0);

        // 5. Flush with a simultaneous write: the flush-cycle word must vanish.
        tick();
        s_valid = 1'b1;
        s_data  = 8'h21;
        tick();
        s_data  = 8'h22;
        tick();
        s_data  = 8'h23;
        tick();
        clr     = 1'b1;
        s_data  = 8'hEE;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("clr_m_valid", 32'(m_valid), 32'd0);
        check("clr_count", 32'(count), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("clr_still_empty", 32'(m_valid), 32'd0);
        tick();
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        s_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("clr_next_head", 32'(m_data), 32'h5A);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Asynchronous reset while holding data.
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (2) tick();
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        // 6. Random traffic with phases biased towards filling, draining and balance.
        for (int c = 0; c < 10000; c++) begin
            tick();
            phase   = (c / 400) % 3;
            s_valid = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            m_ready = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 499) == 0);
            s_data  = 8'($urandom);
        end
        tick();
        s_valid = 1'b0;
        clr     = 1'b0;
        m_ready = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        check("final_count", 32'(count), 32'd0);
        check("final_m_valid", 32'(m_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
